// File: rtl/img_stream_pkg.sv
// Shared definitions for the image streaming stages (crop, bin).
// Default pixel width, counter-width helper and the binning rounding constant.
package img_stream_pkg;

   localparam int DEFAULT_PIXEL_BIT_WIDTH = 12;

   // Added to a four-pixel sum before the divide-by-four when rounding is enabled.
   localparam int BIN_ROUND_CONST = 2;

   // Bits needed to hold any value in 0..n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bin2x2_line_buffer.sv
// Single-write, single-read line buffer holding the horizontal pair sums of an even row.
// Read is asynchronous so the binned result still lands one register stage after the pixel.
module bin2x2_line_buffer
   import img_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_PIXEL_BIT_WIDTH + 1,
   parameter int DEPTH = 10,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage is not reset: every entry is written on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/bin2x2_filter.sv
// 2x2 binning filter: raster pixel stream in, half-resolution averaged stream out (valid/ready).
// Define BIN2X2_ROUND_EN to round half up instead of truncating the average.
module bin2x2_filter
   import img_stream_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH = DEFAULT_PIXEL_BIT_WIDTH,
   parameter int IN_ROWS         = 20,
   parameter int IN_COLS         = 20
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int W     = PIXEL_BIT_WIDTH;
   localparam int XW    = cnt_width(IN_COLS - 1);
   localparam int YW    = cnt_width(IN_ROWS - 1);
   localparam int DEPTH = IN_COLS / 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [XW-1:0]  X_LAST    = XW'(IN_COLS - 1);
   localparam logic [YW-1:0]  Y_LAST    = YW'(IN_ROWS - 1);
   localparam logic [W+1:0]   ROUND_ADD = (W + 2)'(BIN_ROUND_CONST);

   logic [XW-1:0] x_r;
   logic [YW-1:0] y_r;
   logic [XW-1:0] x_next_s;
   logic [YW-1:0] y_next_s;
   logic [W-1:0]  hold_r;
   logic [W-1:0]  pixel_out_r;
   logic          out_valid_r;

   logic          in_ready_s;
   logic          acc_s;
   logic          load_s;
   logic          lb_we_s;
   logic [AW-1:0] lb_addr_s;
   logic [W:0]    lb_rdata_s;
   logic [W:0]    hsum_s;
   logic [W+1:0]  bsum_s;
   logic [W+1:0]  rounded_s;
   logic [W-1:0]  result_s;

   assign in_ready_s = !out_valid_r || out_ready;
   assign acc_s      = in_valid && in_ready_s;
   assign lb_we_s    = acc_s && x_r[0] && !y_r[0];
   assign load_s     = acc_s && x_r[0] && y_r[0];
   assign lb_addr_s  = AW'(x_r >> 1);

   assign hsum_s = {1'b0, hold_r} + {1'b0, pixel_in};
   assign bsum_s = {1'b0, lb_rdata_s} + {1'b0, hsum_s};

`ifdef BIN2X2_ROUND_EN
   // Cannot overflow: 4*(2^W-1)+2 still fits in W+2 bits.
   assign rounded_s = bsum_s + ROUND_ADD;
`else
   assign rounded_s = bsum_s;
`endif

   assign result_s = W'(rounded_s >> 2);

   bin2x2_line_buffer #(
      .WIDTH (W + 1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_line_buffer (
      .clk   (clk),
      .we    (lb_we_s),
      .waddr (lb_addr_s),
      .wdata (hsum_s),
      .raddr (lb_addr_s),
      .rdata (lb_rdata_s)
   );

   // Raster position advance with wrap at end of line and end of frame.
   always_comb begin
      x_next_s = x_r;
      y_next_s = y_r;
      if (acc_s) begin
         if (x_r == X_LAST) begin
            x_next_s = {XW{1'b0}};
            if (y_r == Y_LAST) begin
               y_next_s = {YW{1'b0}};
            end else begin
               y_next_s = y_r + YW'(1);
            end
         end else begin
            x_next_s = x_r + XW'(1);
            y_next_s = y_r;
         end
      end else begin
         x_next_s = x_r;
         y_next_s = y_r;
      end
   end

   // Position counters and the even-column pixel holding register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_r    <= {XW{1'b0}};
         y_r    <= {YW{1'b0}};
         hold_r <= {W{1'b0}};
      end else begin
         x_r <= x_next_s;
         y_r <= y_next_s;
         if (acc_s && !x_r[0]) begin
            hold_r <= pixel_in;
         end
      end
   end

   // Single-entry output register; a new result may replace the one being popped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_out_r <= {W{1'b0}};
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         pixel_out_r <= result_s;
         out_valid_r <= 1'b1;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign pixel_out = pixel_out_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_bin2x2_filter.sv
// Self-checking bench for bin2x2_filter: a 4x4 instance for directed tests and a 20x20 instance for random traffic.
module tb_bin2x2_filter;

   localparam int W = 12;
`ifdef BIN2X2_ROUND_EN
   localparam int RND = 2;
`else
   localparam int RND = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] s_pix = '0, s_po, b_pix = '0, b_po;
   logic s_iv = 1'b0, s_ir, s_ov, s_or = 1'b1;
   logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1;

   bin2x2_filter #(.PIXEL_BIT_WIDTH(W), .IN_ROWS(4), .IN_COLS(4)) u_small (
      .clk(clk), .reset(reset), .pixel_in(s_pix), .in_valid(s_iv), .in_ready(s_ir),
      .pixel_out(s_po), .out_valid(s_ov), .out_ready(s_or));

   bin2x2_filter #(.PIXEL_BIT_WIDTH(W), .IN_ROWS(20), .IN_COLS(20)) u_big (
      .clk(clk), .reset(reset), .pixel_in(b_pix), .in_valid(b_iv), .in_ready(b_ir),
      .pixel_out(b_po), .out_valid(b_ov), .out_ready(b_or));

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cmp_q(input string name, input int got[$], input int exp[$]);
      check({name, " count"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
   endtask

   // Handshake monitor and stall-stability watcher
   int s_acc_cnt = 0, b_acc_cnt = 0, b_hold_err = 0, b_stall_pix = 0;
   logic b_stall = 1'b0;
   int s_got[$], b_got[$];

   always @(posedge clk) begin
      if (s_iv && s_ir) s_acc_cnt <= s_acc_cnt + 1;
      if (s_ov && s_or) s_got.push_back(int'(s_po));
      if (b_iv && b_ir) b_acc_cnt <= b_acc_cnt + 1;
      if (b_ov && b_or) b_got.push_back(int'(b_po));
      b_hold_err <= b_hold_err + ((b_stall && !(b_ov && int'(b_po) == b_stall_pix)) ? 1 : 0)
                                + ((b_ov && !b_or && b_ir) ? 1 : 0);
      b_stall     <= b_ov && !b_or;
      b_stall_pix <= int'(b_po);
   end

   task automatic s_send(input int p);
      int start;
      bit done;
      @(negedge clk);
      start = s_acc_cnt;
      s_pix = W'(p);
      s_iv = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 1000 && !done; k++) begin
         @(posedge clk); #1;
         if (s_acc_cnt != start) done = 1'b1;
      end
      if (!done) check("s_send timeout", 0, 1);
   endtask

   task automatic b_send(input int p);
      int start;
      bit done;
      @(negedge clk);
      start = b_acc_cnt;
      b_pix = W'(p);
      b_iv = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 1000 && !done; k++) begin
         @(posedge clk); #1;
         if (b_acc_cnt != start) done = 1'b1;
      end
      if (!done) check("b_send timeout", 0, 1);
   endtask

   task automatic s_idle(input int n);
      @(negedge clk);
      s_iv = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      int pix;
      int exp_v;
      int exp_p;
   } vec_t;

   vec_t tbl[16];
   int exp_s[$];
   int exp_b[$];
   int frame[400];
   bit b_run;

   initial begin
`ifdef BIN2X2_ROUND_EN
      exp_s = '{4, 6, 12, 14};
`else
      exp_s = '{3, 5, 11, 13};
`endif
      for (int i = 0; i < 16; i++) begin
         tbl[i].pix   = i + 1;
         tbl[i].exp_v = (i == 5 || i == 7 || i == 13 || i == 15) ? 1 : 0;
         tbl[i].exp_p = (i == 5) ? exp_s[0] : (i == 7) ? exp_s[1] : (i == 13) ? exp_s[2] : (i == 15) ? exp_s[3] : 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("in reset out_valid", int'(s_ov), 0);
      check("in reset pixel_out", int'(s_po), 0);
      reset = 1'b1;
      #1;
      check("after reset in_ready", int'(s_ir), 1);
      check("after reset out_valid", int'(s_ov), 0);
      check("after reset pixel_out", int'(s_po), 0);

      // Test 1: table-driven 1..16 with out_ready=1
      s_got.delete();
      for (int i = 0; i < 16; i++) begin
         s_send(tbl[i].pix);
         check($sformatf("t1 out_valid px%0d", tbl[i].pix), int'(s_ov), tbl[i].exp_v);
         if (tbl[i].exp_v != 0)
            check($sformatf("t1 pixel_out px%0d", tbl[i].pix), int'(s_po), tbl[i].exp_p);
      end
      s_idle(2);
      cmp_q("t1 stream", s_got, exp_s);

      // Test 2: saturated input never wraps
      s_got.delete();
      for (int i = 0; i < 16; i++) s_send(4095);
      s_idle(2);
      cmp_q("t2 max", s_got, '{4095, 4095, 4095, 4095});

      // Test 3: backpressure for 10 cycles after the first output
      s_got.delete();
      for (int i = 1; i <= 6; i++) s_send(i);
      @(negedge clk);
      s_or = 1'b0;
      s_pix = W'(7);
      s_iv = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("t3 stall out_valid", int'(s_ov), 1);
         check("t3 stall pixel_out", int'(s_po), exp_s[0]);
         check("t3 stall in_ready", int'(s_ir), 0);
      end
      s_or = 1'b1;
      for (int i = 7; i <= 16; i++) s_send(i);
      s_idle(2);
      cmp_q("t3 after release", s_got, exp_s);

      // Test 4: two back-to-back frames
      s_got.delete();
      for (int f = 0; f < 2; f++)
         for (int i = 1; i <= 16; i++) s_send(i);
      s_idle(2);
      cmp_q("t4 two frames", s_got, {exp_s, exp_s});

      // Test 5: reset after pixel 7 discards the partial frame
      for (int i = 1; i <= 7; i++) s_send(i);
      @(negedge clk);
      s_iv = 1'b0;
      reset = 1'b0;
      #1;
      check("t5 reset out_valid", int'(s_ov), 0);
      check("t5 reset pixel_out", int'(s_po), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      s_got.delete();
      for (int i = 1; i <= 16; i++) s_send(i);
      s_idle(2);
      cmp_q("t5 after reset", s_got, exp_s);

      // Test 6: random 20x20 frame with random gaps against a block-average model
      for (int i = 0; i < 400; i++) frame[i] = int'($urandom_range(0, 4095));
      exp_b.delete();
      for (int by = 0; by < 10; by++)
         for (int bx = 0; bx < 10; bx++)
            exp_b.push_back((frame[(2*by)*20 + 2*bx] + frame[(2*by)*20 + 2*bx + 1] +
                             frame[(2*by+1)*20 + 2*bx] + frame[(2*by+1)*20 + 2*bx + 1] + RND) / 4);
      b_got.delete();
      b_acc_cnt = 0;
      b_run = 1'b1;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(negedge clk);
                  b_iv = 1'b0;
                  repeat ($urandom_range(0, 3)) @(negedge clk);
               end
               b_send(frame[i]);
            end
            @(negedge clk);
            b_iv = 1'b0;
            for (int k = 0; k < 500 && b_got.size() < 100; k++) @(negedge clk);
            b_run = 1'b0;
         end
         begin
            while (b_run) begin
               @(negedge clk);
               b_or = ($urandom_range(0, 99) < 65);
            end
            b_or = 1'b1;
         end
      join
      repeat (2) @(negedge clk);
      check("t6 accepted pixels", b_acc_cnt, 400);
      check("t6 stall stability", b_hold_err, 0);
      cmp_q("t6 random", b_got, exp_b);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bin2x2_filter.md
# bin2x2_filter

Downstream neighbour of the crop stage: consumes the cropped pixel stream in raster order and emits a 2×2-binned (averaged) image at half resolution in each dimension. A line buffer holds horizontal pair sums from even rows, and an output register drives a valid/ready stream. It sits between the crop filter and the downstream image consumer.

## Interface
- PIXEL_BIT_WIDTH, 12, bits per input and output pixel
- IN_ROWS, 20, input image rows; must be even and ≥2
- IN_COLS, 20, input image columns; must be even and ≥2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; name kept as `reset`, asserted when 0
- pixel_in  input  PIXEL_BIT_WIDTH  input pixel
- in_valid  input  1  pixel_in is valid
- in_ready  output  1  block can accept a pixel this cycle
- pixel_out  output  PIXEL_BIT_WIDTH  binned pixel
- out_valid  output  1  pixel_out is valid
- out_ready  input  1  downstream accepts pixel_out

## Operation
- Accept: `acc = in_valid & in_ready`. Counters x (0..IN_COLS-1) and y (0..IN_ROWS-1) advance only on acc, in raster order.
- Even x: register pixel_in into `hold`.
- Odd x: `hsum = hold + pixel_in`, PIXEL_BIT_WIDTH+1 bits.
  - Even y: write hsum to `line_buf[x>>1]`. Buffer depth is IN_COLS/2.
  - Odd y: `bsum = line_buf[x>>1] + hsum`, PIXEL_BIT_WIDTH+2 bits. Load `pixel_out = bsum >> 2` (see Configuration) and set out_valid.
- Output register: a single entry. Hold out_valid and pixel_out stable while `out_valid & !out_ready`. Clear out_valid on `out_valid & out_ready` unless a new result loads in the same cycle.
- `in_ready = !out_valid | out_ready`. This is combinational, with no dependency on in_valid.
- Wrap-around: when acc occurs at x=IN_COLS-1, set x to 0 and increment y. At y=IN_ROWS-1, y wraps to 0 and the next frame starts with no gap.
- Overflow: none. bsum cannot exceed 4·(2^PIXEL_BIT_WIDTH − 1), and the result after the shift always fits PIXEL_BIT_WIDTH bits.
- Reset values: x, y, hold, pixel_out = 0; out_valid = 0; in_ready = 1 on the first cycle after release. line_buf is not reset, because every entry is written before it is read.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0).
- Out-of-frame pixels: none exist. The upstream valid stream must carry exactly IN_ROWS·IN_COLS pixels per frame.

## Timing
- Latency: pixel_out and out_valid are registered 1 cycle after the acc of pixel (odd x, odd y).
- Throughput: 1 pixel per clock in; at most 1 output per 4 inputs.
- Simultaneous pop and load: with `out_valid & out_ready & acc` at odd x and odd y, the new result replaces the old one and out_valid stays 1.
- Backpressure: in_ready falls in the same cycle that `out_valid & !out_ready` holds. No pixel is dropped.
- line_buf read is asynchronous, or synchronous with the address presented one pixel early (on even x). Either way, the bsum-to-pixel_out path stays at one register stage.

## Configuration
- `BIN2X2_ROUND_EN` defined: `pixel_out = (bsum + 2) >> 2`, i.e. round half up. The +2 is computed in PIXEL_BIT_WIDTH+2 bits with no overflow; the maximum input still yields 2^PIXEL_BIT_WIDTH − 1.
- Not defined: `pixel_out = bsum >> 2`, i.e. truncation.

## Structure
- Shared package `img_stream_pkg`: default PIXEL_BIT_WIDTH, a counter-width helper (clog2(N+1), as used by the crop stage), and the rounding constant.
- One sub-module, `bin2x2_line_buffer`: parameters WIDTH and DEPTH, with one write port and one read port, holding the even-row pair sums.

## Test plan
- IN_ROWS=4, IN_COLS=4, stream 1..16 in raster order, out_ready=1 → outputs 3,5,11,13 (truncate) or 4,6,12,14 (`BIN2X2_ROUND_EN`), each 1 cycle after pixels 6, 8, 14, 16.
- All pixels 4095 → every output 4095 in both configurations; no wrap to 0.
- out_ready held 0 after the first output → out_valid stays 1, pixel_out stays stable, in_ready=0. Release after 10 cycles → no input lost, and the remaining outputs match the first test.
- Two back-to-back frames with in_valid=1 continuously and out_ready=1 → second frame outputs are identical to the first; x and y return to 0 after pixel 16.
- Assert reset (0) after pixel 7 of frame 1, then stream a full frame → exactly 4 correct outputs; out_valid=0 and pixel_out=0 during reset.
- Random in_valid and out_ready gaps on a 20×20 frame → 100 outputs matching the reference-model averages; never more than one pending output.
